instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational instruction ROM (16-bit word address in, 32-bit LEGv8 word out). It owns the program counter, drives the ROM address, and registers each fetched word into a valid/ready slot for decode. It resolves unconditional B locally by predecode, accepts PC redirects from execute, and halts on the BR XZR terminator word.

Parameters:
ADDR_W, 16, ROM word-address width; PC width.
RESET_PC, 16'h0000, PC value loaded at reset.
HALT_WORD, 32'hD60003E0, instruction word that stops fetch (BR XZR).
PREDECODE_B, 1, when 1, B (opcode[31:26]=6'b000101) is redirected in fetch.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins fetching from the current PC.
rom_addr  out  ADDR_W  ROM address; combinationally equal to pc.
rom_data  in  32  ROM output word (combinational, same cycle).
out_valid  out  1  fetch slot holds an instruction.
out_ready  in  1  decode accepts the slot this cycle.
out_instr  out  32  registered instruction word.
out_pc  out  ADDR_W  word address of out_instr.
out_pred_taken  out  1  out_instr is a B already redirected by fetch.
redirect_valid  in  1  execute redirect/flush request.
redirect_addr  in  ADDR_W  new PC for a redirect.
halted  out  1  HALT_WORD was fetched; fetch stopped.
busy  out  1  state is FETCH.
fetch_count  out  32  number of accepted handshakes (out_valid & out_ready), saturating.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pred_taken=0, halted=0, fetch_count=0. Deasserting reset mid-fetch restarts from IDLE with no residual valid.
- States: IDLE, FETCH, HALT. busy=1 only in FETCH.
- IDLE: start=1 -> FETCH on the next edge. Redirects are ignored; out_valid stays 0.
- FETCH, slot free (out_valid=0, or out_ready=1): capture on the edge: out_instr=rom_data, out_pc=pc, out_valid=1. Fetching runs at one word per cycle, with one cycle of latency from rom_addr to out_valid.
  - rom_data==HALT_WORD: the word is not captured and out_valid is cleared if consumed. pc holds, halted=1, state goes to HALT.
  - PREDECODE_B=1 and rom_data[31:26]==6'b000101: pc = pc + rom_data[ADDR_W-1:0] (imm26 truncated to ADDR_W, mod 2^ADDR_W). out_pred_taken=1 and the word is forwarded.
  - Otherwise pc=pc+1, wrapping 16'hFFFF -> 16'h0000, and out_pred_taken=0.
- FETCH, stall (out_valid=1, out_ready=0): pc, the slot, and the state all hold. rom_addr remains pc.
- Redirect (redirect_valid=1 in FETCH): highest priority, and it overrides capture and stall in the same cycle. On the next edge pc=redirect_addr, out_valid=0, and out_pred_taken=0. No word is captured that cycle. A handshake in the same cycle still counts in fetch_count.
- HALT: all inputs except reset are ignored, including start and redirect_valid. halted stays 1. A pending slot drains normally when out_ready=1, then out_valid=0.
- start while in FETCH or HALT: ignored.
- fetch_count: increments on out_valid & out_ready and saturates at 32'hFFFFFFFF. It also increments in HALT while draining.

Test Plan:
- Straight-line: ROM program 0..9, start pulse, out_ready=1 -> out_pc sequence 0,1,2,3,4,...,9. out_valid rises one cycle after busy. out_instr at pc 2 is 32'h8B020021.
- Loop predecode: B at word 9 (imm26=-7) -> next out_pc=2. out_pred_taken=1 only on the pc-9 word. No bubble between pc 9 and pc 2.
- Halt: ROM word at 10 equals 32'hD60003E0, jump at 9 disabled -> after pc 9 is accepted, halted=1, out_valid=0, pc holds 10. A later start produces no fetch. fetch_count=10.
- Backpressure: out_ready=0 for 5 cycles at out_pc=4 -> out_instr/out_pc stable, rom_addr=5 held. After release, out_pc=5 follows in the next cycle.
- Redirect vs stall: slot valid at pc 6, out_ready=0, redirect_valid=1 with addr 16'h0003 -> next cycle out_valid=0 and pc=3. The following cycle has out_pc=3.
- Wrap and reset: redirect to 16'hFFFF with a non-branch word -> next pc=16'h0000. Asserting rst_n=0 mid-stall immediately clears out_valid, halted, and fetch_count, and pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational ROM
// address, registers fetched words into a valid/ready slot, predecodes
// unconditional B, accepts execute redirects and stops on the halt word.
module instr_fetch_ctrl #(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [31:0]       HALT_WORD   = 32'hD60003E0,
  parameter bit                PREDECODE_B = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_pred_taken,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              busy,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic              pred_q, pred_d;
  logic              halted_q, halted_d;
  logic [31:0]       count_q, count_d;

  logic consume;
  logic slot_free;
  logic is_b;
  logic is_halt;

  assign consume   = valid_q & out_ready;
  assign slot_free = ~valid_q | out_ready;
  assign is_halt   = (rom_data == HALT_WORD);
  assign is_b      = PREDECODE_B && (rom_data[31:26] == 6'b000101);

  // Next-state, PC and slot update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    pred_d   = pred_q;
    halted_d = halted_q;
    count_d  = count_q;

    // Handshakes count in every state, redirect cycles included.
    if (consume && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          valid_d = 1'b0;
          pred_d  = 1'b0;
        end else if (slot_free) begin
          if (is_halt) begin
            // Halt word is never forwarded; the slot is empty or just drained.
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = StHalt;
          end else begin
            valid_d = 1'b1;
            instr_d = rom_data;
            opc_d   = pc_q;
            if (is_b) begin
              // imm26 truncated to the PC width, wrapping modulo 2^ADDR_W.
              pc_d   = pc_q + rom_data[ADDR_W-1:0];
              pred_d = 1'b1;
            end else begin
              pc_d   = pc_q + 1'b1;
              pred_d = 1'b0;
            end
          end
        end
      end
      StHalt: begin
        if (consume) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      opc_q    <= '0;
      pred_q   <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      pred_q   <= pred_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign rom_addr       = pc_q;
  assign out_valid      = valid_q;
  assign out_instr      = instr_q;
  assign out_pc         = opc_q;
  assign out_pred_taken = pred_q;
  assign halted         = halted_q;
  assign busy           = (state_q == StFetch);
  assign fetch_count    = count_q;

endmodule
